hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core.
- Issues per-stage stall/flush strobes to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and EX-stage redirects (taken branch, jal, jalr).
- Runs a wait-state FSM for a multi-cycle data memory with timeout, and keeps stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, EX redirect and data-memory wait-state handling.
// Strobes are combinational; mem_err and the performance counters are registered.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] to_cnt, to_cnt_nxt;
    logic       err_nxt;
    logic       mem_stall;
    logic       lu;
    logic       redirect_applied;

    assign lu = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            to_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        err_nxt    = 1'b0;
        mem_stall  = 1'b0;
        case (state)
            S_IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    mem_stall  = 1'b1;
                    state_nxt  = S_WAIT;
                    to_cnt_nxt = 8'd0;
                end
            end
            S_WAIT: begin
                if (!dmem_req || dmem_ack) begin
                    state_nxt = S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    // Give up: release the pipeline now, flag the error next cycle.
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    mem_stall  = 1'b1;
                    to_cnt_nxt = to_cnt + 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign redirect_applied = !rst && ex_redirect && !mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            mem_err <= err_nxt;
            if (pc_stall)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect_applied)
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of combinational vectors plus multi-cycle memory/reset sequences.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, dmem_req, dmem_ack;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic          mem_err;
    logic [CW-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic       req;
        logic       ack;
    } vin_t;

    typedef struct {
        string      name;
        vin_t       v;
        logic [6:0] exp;
    } vec_t;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] RDIR = 7'b0010100;
    localparam logic [6:0] MS   = 7'b1101011;

    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] sb[$];
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;

    function automatic vin_t mk(logic vld, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic mr, logic [4:0] rd, logic redir, logic req, logic ack);
        vin_t v;
        v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.mr = mr; v.rd = rd; v.redir = redir; v.req = req; v.ack = ack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vin_t v);
        id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_mem_read = v.mr; ex_rd = v.rd; ex_redirect = v.redir;
        dmem_req = v.req; dmem_ack = v.ack;
    endtask

    function automatic logic [6:0] strobes();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
    endfunction

    task automatic check_strobes(input string name);
        logic [6:0] e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({name, "_strobes"}, 32'(strobes()), 32'(e));
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input string name, input vin_t v, input logic [6:0] exp, input logic exp_err);
        apply(v);
        sb.push_back(exp);
        #2;
        check_strobes(name);
        if (exp[6]) exp_stall = exp_stall + 1;
        if (v.redir && !exp[0]) exp_flush = exp_flush + 1;
        @(posedge clk);
        #1;
        chk({name, "_stall_cycles"}, stall_cycles, exp_stall);
        chk({name, "_flush_events"}, flush_events, exp_flush);
        chk({name, "_mem_err"}, 32'(mem_err), 32'(exp_err));
    endtask

    vec_t tbl[$];
    vin_t idle_v, req_v, ack_v, lu_v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu_v   = mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0);
        req_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        ack_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        tbl.push_back('{"lu_rs1",       lu_v,                                NONE | LU});
        tbl.push_back('{"lu_rd0",       mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0),   NONE});
        tbl.push_back('{"redir_lu",     mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 0),   RDIR});
        tbl.push_back('{"lu_rs2",       mk(1, 3, 9, 0, 1, 1, 9, 0, 0, 0),   LU});
        tbl.push_back('{"rs2_unused",   mk(1, 3, 9, 1, 0, 1, 9, 0, 0, 0),   NONE});
        tbl.push_back('{"id_invalid",   mk(0, 7, 0, 1, 0, 1, 7, 0, 0, 0),   NONE});
        tbl.push_back('{"not_load",     mk(1, 7, 0, 1, 0, 0, 7, 0, 0, 0),   NONE});
        tbl.push_back('{"redir_only",   mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),   RDIR});
        tbl.push_back('{"single_mem",   mk(1, 4, 4, 1, 1, 1, 4, 0, 1, 1),   LU});
        tbl.push_back('{"rs1_mismatch", mk(1, 6, 0, 1, 0, 1, 31, 0, 0, 0),  NONE});

        // Reset state: strobes masked even with a live load-use pattern.
        rst = 1'b1;
        apply(lu_v);
        #3;
        chk("rst_strobes", 32'(strobes()), 32'(NONE));
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_flush_events", flush_events, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].v, tbl[i].exp, 1'b0);

        // Memory wait, ack on the 4th cycle.
        for (int i = 0; i < 3; i++) step("wait_stall", req_v, MS, 1'b0);
        step("wait_ack", ack_v, NONE, 1'b0);
        step("wait_after", idle_v, NONE, 1'b0);

        // Timeout: TO frozen cycles, release on the last WAIT evaluation, mem_err next.
        for (int i = 0; i < TO; i++) step("to_stall", req_v, MS, 1'b0);
        step("to_release", req_v, NONE, 1'b1);
        step("to_after", idle_v, NONE, 1'b0);

        // New request in the mem_err cycle starts normally from IDLE.
        for (int i = 0; i < TO; i++) step("to2_stall", req_v, MS, 1'b0);
        step("to2_release", req_v, NONE, 1'b1);
        step("to2_new_req", req_v, MS, 1'b0);
        step("to2_ack", ack_v, NONE, 1'b0);

        // Redirect deferred across a 2-cycle memory wait, applied on release.
        for (int i = 0; i < 2; i++) step("defer_stall", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MS, 1'b0);
        step("defer_release", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), RDIR, 1'b0);
        step("defer_after", idle_v, NONE, 1'b0);

        // Async reset in the middle of WAIT, just before it would time out.
        for (int i = 0; i < TO - 1; i++) step("arst_stall", req_v, MS, 1'b0);
        apply(req_v);
        #2;
        chk("arst_pre_strobes", 32'(strobes()), 32'(MS));
        rst = 1'b1;
        #1;
        chk("arst_strobes", 32'(strobes()), 32'(NONE));
        chk("arst_stall_cycles", stall_cycles, 32'd0);
        chk("arst_flush_events", flush_events, 32'd0);
        exp_stall = '0;
        exp_flush = '0;
        @(posedge clk);
        #1;
        chk("arst_held_mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("arst_after", idle_v, NONE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
